// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for the filter GPU datapath.
// Accepts one instruction per valid/ready handshake, decodes it into the
// datapath control bundle and sequences MUL/CONV steps and memory accesses.
// Optional build macro: CU_MEM_TIMEOUT_EN adds a watchdog that aborts a memory
// access after MEM_TIMEOUT cycles without mem_ack and pulses mem_err.
module control_sequencer #(
    parameter int INSTR_W     = 28,
    parameter int ALUC_W      = 3,
    parameter int MUL_CYCLES  = 2,
    parameter int CONV_TAPS   = 9,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] Instr,
    input  logic               mem_ack,
    input  logic               flush,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUSrc,
    output logic [1:0]         RegSrc,
    output logic [ALUC_W-1:0]  ALUControl,
    output logic [7:0]         step_idx,
    output logic               busy,
    output logic               op_done,
    output logic               illegal,
    output logic               mem_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        MULTI = 2'd2,
        MEM   = 2'd3
    } state_t;

    localparam logic [ALUC_W-1:0] ALU_ADD   = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB   = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND   = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_MUL   = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_CONV  = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] ALU_PASSB = ALUC_W'(5);

    localparam logic [7:0] MUL_LAST  = 8'(MUL_CYCLES - 1);
    localparam logic [7:0] CONV_LAST = 8'(CONV_TAPS - 1);

    state_t state_q;
    state_t state_d;

    // Decoded view of the incoming instruction, captured only on acceptance
    state_t             dec_state;
    logic               dec_ill;
    logic               dec_ldr;
    logic               dec_str;
    logic [1:0]         dec_imm_src;
    logic [1:0]         dec_alu_src;
    logic [1:0]         dec_reg_src;
    logic [ALUC_W-1:0]  dec_aluc;
    logic [7:0]         dec_last;

    // Registered control bundle for the op in progress
    logic               ill_q;
    logic               ldr_q;
    logic               str_q;
    logic [1:0]         imm_src_q;
    logic [1:0]         alu_src_q;
    logic [1:0]         reg_src_q;
    logic [ALUC_W-1:0]  aluc_q;
    logic [7:0]         last_q;
    logic [7:0]         step_q;

    logic               accept;
    logic               ready_c;
    logic               done_c;

`ifdef CU_MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
`endif

    // Instruction bits outside the decoded fields are intentionally ignored
    logic unused_ok;
    assign unused_ok = &{1'b0, Instr[INSTR_W-1:18], Instr[11:5], Instr[3:0], (MEM_TIMEOUT > 0)};

    // Decode the raw instruction into the next op's state and control bundle
    always_comb begin
        dec_state   = EXEC;
        dec_ill     = 1'b0;
        dec_ldr     = 1'b0;
        dec_str     = 1'b0;
        dec_imm_src = 2'b00;
        dec_alu_src = 2'b00;
        dec_reg_src = 2'b00;
        dec_aluc    = ALU_ADD;
        dec_last    = 8'd0;
        case (Instr[17:16])
            2'b00: begin
                dec_alu_src = {1'b0, Instr[4]};
                case (Instr[15:12])
                    4'd0: dec_aluc = ALU_ADD;
                    4'd1: dec_aluc = ALU_SUB;
                    4'd2: dec_aluc = ALU_AND;
                    4'd3: begin
                        dec_aluc  = ALU_MUL;
                        dec_state = MULTI;
                        dec_last  = MUL_LAST;
                    end
                    4'd4: begin
                        dec_aluc    = ALU_CONV;
                        dec_alu_src = 2'b10;
                        dec_state   = MULTI;
                        dec_last    = CONV_LAST;
                    end
                    default: begin
                        dec_ill     = 1'b1;
                        dec_alu_src = 2'b00;
                    end
                endcase
            end
            2'b01: begin
                dec_state   = MEM;
                dec_imm_src = 2'b01;
                dec_alu_src = {1'b0, Instr[4]};
                dec_aluc    = ALU_ADD;
                if (Instr[12]) begin
                    dec_ldr = 1'b1;
                end else begin
                    dec_str     = 1'b1;
                    dec_reg_src = 2'b10;
                end
            end
            2'b10: begin
                dec_imm_src = 2'b10;
                dec_alu_src = 2'b01;
                dec_reg_src = 2'b01;
                dec_aluc    = ALU_PASSB;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Output decode and next-state selection; flush overrides completion and acceptance
    always_comb begin
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        MemToReg   = 1'b0;
        ImmSrc     = 2'b00;
        ALUSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = '0;
        step_idx   = 8'd0;
        busy       = 1'b0;
        done_c     = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        ready_c    = 1'b0;
        accept     = 1'b0;
        state_d    = state_q;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
            end
            EXEC: begin
                busy       = 1'b1;
                done_c     = 1'b1;
                ImmSrc     = imm_src_q;
                ALUSrc     = alu_src_q;
                RegSrc     = reg_src_q;
                ALUControl = aluc_q;
                if (ill_q) begin
                    illegal = 1'b1;
                end else begin
                    RegWrite = 1'b1;
                end
            end
            MULTI: begin
                busy       = 1'b1;
                ImmSrc     = imm_src_q;
                ALUSrc     = alu_src_q;
                RegSrc     = reg_src_q;
                ALUControl = aluc_q;
                step_idx   = step_q;
                if (step_q == last_q) begin
                    RegWrite = 1'b1;
                    done_c   = 1'b1;
                end
            end
            MEM: begin
                busy       = 1'b1;
                ImmSrc     = imm_src_q;
                ALUSrc     = alu_src_q;
                RegSrc     = reg_src_q;
                ALUControl = aluc_q;
                MemWrite   = str_q;
                MemToReg   = ldr_q;
                if (mem_ack) begin
                    done_c   = 1'b1;
                    RegWrite = ldr_q;
                end
`ifdef CU_MEM_TIMEOUT_EN
                else if (wd_q == WD_W'(MEM_TIMEOUT - 1)) begin
                    done_c   = 1'b1;
                    mem_err  = 1'b1;
                    MemWrite = 1'b0;
                end
`endif
            end
            default: ;
        endcase

        if (done_c) begin
            ready_c = 1'b1;
        end

        if (flush) begin
            done_c   = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
            mem_err  = 1'b0;
            ready_c  = 1'b0;
        end

        if (reset) begin
            ready_c = 1'b0;
        end

        accept = instr_valid & ready_c;

        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = dec_state;
        end else if (done_c) begin
            state_d = IDLE;
        end
    end

    assign op_done     = done_c;
    assign instr_ready = ready_c;

    // State register
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the decoded bundle on acceptance and advance the step/watchdog counters
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            ill_q     <= 1'b0;
            ldr_q     <= 1'b0;
            str_q     <= 1'b0;
            imm_src_q <= 2'b00;
            alu_src_q <= 2'b00;
            reg_src_q <= 2'b00;
            aluc_q    <= '0;
            last_q    <= 8'd0;
            step_q    <= 8'd0;
`ifdef CU_MEM_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else if (accept) begin
            ill_q     <= dec_ill;
            ldr_q     <= dec_ldr;
            str_q     <= dec_str;
            imm_src_q <= dec_imm_src;
            alu_src_q <= dec_alu_src;
            reg_src_q <= dec_reg_src;
            aluc_q    <= dec_aluc;
            last_q    <= dec_last;
            step_q    <= 8'd0;
`ifdef CU_MEM_TIMEOUT_EN
            wd_q      <= '0;
`endif
        end else begin
            if (state_q == MULTI) begin
                step_q <= step_q + 8'd1;
            end
`ifdef CU_MEM_TIMEOUT_EN
            if (state_q == MEM) begin
                wd_q <= wd_q + WD_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer.
// Honours CU_MEM_TIMEOUT_EN when the design is built with it.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [27:0] Instr;
    logic        mem_ack;
    logic        flush;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemToReg;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUSrc;
    logic [1:0]  RegSrc;
    logic [2:0]  ALUControl;
    logic [7:0]  step_idx;
    logic        busy;
    logic        op_done;
    logic        illegal;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    control_sequencer dut (
        .Clock       (Clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Instr       (Instr),
        .mem_ack     (mem_ack),
        .flush       (flush),
        .RegWrite    (RegWrite),
        .MemWrite    (MemWrite),
        .MemToReg    (MemToReg),
        .ImmSrc      (ImmSrc),
        .ALUSrc      (ALUSrc),
        .RegSrc      (RegSrc),
        .ALUControl  (ALUControl),
        .step_idx    (step_idx),
        .busy        (busy),
        .op_done     (op_done),
        .illegal     (illegal),
        .mem_err     (mem_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 Clock = ~Clock;

    logic [16:0] outs;
    assign outs = {RegWrite, MemWrite, MemToReg, ImmSrc, ALUSrc, RegSrc, ALUControl,
                   busy, op_done, illegal, mem_err, instr_ready};

    localparam logic [16:0] IDLE_V = 17'h00001;

    function automatic logic [16:0] ev(input logic rw, input logic mw, input logic mtr,
                                       input logic [1:0] imm, input logic [1:0] asrc,
                                       input logic [1:0] rsrc, input logic [2:0] aluc,
                                       input logic bsy, input logic done, input logic ill,
                                       input logic err, input logic rdy);
        return {rw, mw, mtr, imm, asrc, rsrc, aluc, bsy, done, ill, err, rdy};
    endfunction

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; instr_valid = 1'b0; Instr = '0; mem_ack = 1'b0; flush = 1'b0;
        @(posedge Clock);
        #2;
        checks++;
        if (outs !== 17'h0 || step_idx !== 8'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b/%0d exp=%b/0", outs, step_idx, 17'h0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL reset_release got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_add;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0000010;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL add_idle got=%b exp=%b", outs, IDLE_V);
        end
        tick;
        instr_valid = 1'b0; Instr = 28'hFFFFFFF;
        #1;
        exp = ev(1, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000, 1, 1, 0, 0, 1);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("[TB] FAIL add_exec got=%b exp=%b", outs, exp);
        end
        tick;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL add_return_idle got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_conv;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0004000;
        tick;
        instr_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            #1;
            exp = ev(k == 8, 0, 0, 2'b00, 2'b10, 2'b00, 3'b100, 1, k == 8, 0, 0, k == 8);
            checks++;
            if (outs !== exp || step_idx !== 8'(k)) begin
                failures++;
                $display("[TB] FAIL conv_step%0d got=%b/%0d exp=%b/%0d", k, outs, step_idx, exp, k);
            end
            tick;
        end
        #1;
        checks++;
        if (outs !== IDLE_V || step_idx !== 8'd0) begin
            failures++;
            $display("[TB] FAIL conv_end got=%b/%0d exp=%b/0", outs, step_idx, IDLE_V);
        end
    endtask

    task automatic test_mul;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0003000;
        tick;
        instr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            exp = ev(k == 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b011, 1, k == 1, 0, 0, k == 1);
            checks++;
            if (outs !== exp || step_idx !== 8'(k)) begin
                failures++;
                $display("[TB] FAIL mul_step%0d got=%b/%0d exp=%b/%0d", k, outs, step_idx, exp, k);
            end
            tick;
        end
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL mul_end got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_ldr;
        logic [16:0] exp;
        mem_ack = 1'b1;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL ack_in_idle got=%b exp=%b", outs, IDLE_V);
        end
        tick;
        mem_ack = 1'b0;
        instr_valid = 1'b1; Instr = 28'h0011000;
        tick;
        instr_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            mem_ack = (c == 4);
            #1;
            exp = ev(c == 4, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 1, c == 4, 0, 0, c == 4);
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("[TB] FAIL ldr_cycle%0d got=%b exp=%b", c, outs, exp);
            end
            tick;
        end
        mem_ack = 1'b0;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL ldr_end got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_str_flush;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0010010;
        tick;
        instr_valid = 1'b0;
        #1;
        exp = ev(0, 1, 0, 2'b01, 2'b01, 2'b10, 3'b000, 1, 0, 0, 0, 0);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("[TB] FAIL str_cycle1 got=%b exp=%b", outs, exp);
        end
        tick;
        flush = 1'b1; mem_ack = 1'b1; instr_valid = 1'b1; Instr = 28'h0000010;
        #1;
        checks++;
        if (op_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL str_flush_done got=%b exp=0", op_done);
        end
        tick;
        flush = 1'b0; mem_ack = 1'b0; instr_valid = 1'b0;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL str_after_flush got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_illegal;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0030000;
        tick;
        Instr = 28'h0007000;
        #1;
        checks++;
        if ({RegWrite, MemWrite, illegal, op_done, instr_ready, busy} !== 6'b001111) begin
            failures++;
            $display("[TB] FAIL illegal_class got=%b exp=%b",
                     {RegWrite, MemWrite, illegal, op_done, instr_ready, busy}, 6'b001111);
        end
        tick;
        Instr = 28'h0000010;
        #1;
        checks++;
        if ({RegWrite, MemWrite, illegal, op_done, instr_ready, busy} !== 6'b001111) begin
            failures++;
            $display("[TB] FAIL illegal_funct got=%b exp=%b",
                     {RegWrite, MemWrite, illegal, op_done, instr_ready, busy}, 6'b001111);
        end
        tick;
        instr_valid = 1'b0;
        #1;
        exp = ev(1, 0, 0, 2'b00, 2'b01, 2'b00, 3'b000, 1, 1, 0, 0, 1);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("[TB] FAIL illegal_back_to_back got=%b exp=%b", outs, exp);
        end
        tick;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL illegal_end got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_mem_timeout;
        logic [16:0] exp;
        instr_valid = 1'b1; Instr = 28'h0010010;
        tick;
        instr_valid = 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            #1;
            if (c < 16) begin
                exp = ev(0, 1, 0, 2'b01, 2'b01, 2'b10, 3'b000, 1, 0, 0, 0, 0);
                checks++;
                if (outs !== exp) begin
                    failures++;
                    $display("[TB] FAIL timeout_wait%0d got=%b exp=%b", c, outs, exp);
                end
            end else begin
                checks++;
                if ({RegWrite, MemWrite, busy, op_done, mem_err, instr_ready} !== 6'b001111) begin
                    failures++;
                    $display("[TB] FAIL timeout_abort got=%b exp=%b",
                             {RegWrite, MemWrite, busy, op_done, mem_err, instr_ready}, 6'b001111);
                end
            end
            tick;
        end
`else
        begin
            int bad;
            bad = 0;
            for (int c = 1; c <= 20; c++) begin
                #1;
                if (mem_err !== 1'b0 || op_done !== 1'b0 || busy !== 1'b1 || MemWrite !== 1'b1) bad++;
                tick;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("[TB] FAIL no_timeout_wait got=%0d bad cycles exp=0", bad);
            end
            mem_ack = 1'b1;
            #1;
            exp = ev(0, 1, 0, 2'b01, 2'b01, 2'b10, 3'b000, 1, 1, 0, 0, 1);
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("[TB] FAIL no_timeout_ack got=%b exp=%b", outs, exp);
            end
            tick;
            mem_ack = 1'b0;
        end
`endif
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL mem_wait_end got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    task automatic test_reset_mid_op;
        instr_valid = 1'b1; Instr = 28'h0004000;
        tick;
        instr_valid = 1'b0;
        tick;
        tick;
        tick;
        #1;
        checks++;
        if (step_idx !== 8'd3 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midop_step got=%0d/%b exp=3/1", step_idx, busy);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (outs !== 17'h0 || step_idx !== 8'd0) begin
            failures++;
            $display("[TB] FAIL midop_async_reset got=%b/%0d exp=%b/0", outs, step_idx, 17'h0);
        end
        #1;
        reset = 1'b0;
        tick;
        #1;
        checks++;
        if (outs !== IDLE_V) begin
            failures++;
            $display("[TB] FAIL midop_after_reset got=%b exp=%b", outs, IDLE_V);
        end
    endtask

    // Directed scenarios in sequence, then the summary line
    initial begin
        $display("[TB] control_sequencer directed test start");
        test_reset;
        test_add;
        test_conv;
        test_mul;
        test_ldr;
        test_str_flush;
        test_illegal;
        test_mem_timeout;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
